// File: rtl/sig_pattern_driver_if.sv
// Bundle of configuration, handshake and observation signals for sig_pattern_driver.
//   master : pattern writes (wr_en/wr_addr/wr_code), run config (len/period/loop),
//            control (start/stop); observes sig_oe/sig_val/busy/done/step_idx
//   slave  : the driver itself
// The tri-state pad (sig) is not part of the bundle; it is a plain port of the driver.
interface sig_pattern_driver_if #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [1:0]       wr_code;
  logic [AW:0]      len;
  logic [DIV_W-1:0] period;
  logic             loop;
  logic             start;
  logic             stop;
  logic             sig_oe;
  logic             sig_val;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step_idx;

  modport master (
    output wr_en, wr_addr, wr_code, len, period, loop, start, stop,
    input  sig_oe, sig_val, busy, done, step_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_code, len, period, loop, start, stop,
    output sig_oe, sig_val, busy, done, step_idx
  );
endinterface

// File: rtl/sig_pattern_driver.sv
// Plays a stored sequence of 2-bit drive codes onto one tri-state line, one code per slot,
// each slot lasting period+1 cycles. Codes: 00 drive 0, 01 drive 1, 10 release (Z),
// 11 hold previous drive. Runs once (done pulse at the end) or loops until stopped.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; releases the line immediately
//   bus   : sig_pattern_driver_if slave (pattern writes, config, start/stop, status)
//   sig   : tri-state line, sig_oe ? sig_val : Z
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | line released, waiting for start
// ST_RUN  | playing slots; busy=1, slot counter counts down per slot
module sig_pattern_driver #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sig_pattern_driver_if.slave  bus,
  output wire                  sig
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [AW:0]      len_q, len_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic             loop_q, loop_d;
  logic             oe_q, oe_d;
  logic             val_q, val_d;
  logic             done_q, done_d;

  logic [1:0]       pat [DEPTH];

  logic [AW:0]      len_clip;
  logic [AW-1:0]    idx_inc;
  logic             last_slot;

  // Applying a code to the current line state; 10 keeps val so a later 11 restores nothing
  // but leaves the last driven level visible on sig_val.
  function automatic logic [1:0] apply_code(input logic [1:0] code, input logic oe,
                                            input logic val);
    logic [1:0] r;
    case (code)
      2'b00:   r = 2'b10;
      2'b01:   r = 2'b11;
      2'b10:   r = {1'b0, val};
      default: r = {oe, val};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pat[i] <= 2'b10;
    end else if (bus.wr_en) begin
      pat[bus.wr_addr] <= bus.wr_code;
    end
  end

  assign len_clip  = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
  assign idx_inc   = idx_q + AW'(1);
  assign last_slot = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    per_d   = per_q;
    loop_d  = loop_q;
    oe_d    = oe_q;
    val_d   = val_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (bus.start && !bus.stop) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d         = ST_RUN;
            idx_d           = '0;
            cnt_d           = bus.period;
            len_d           = len_clip;
            per_d           = bus.period;
            loop_d          = bus.loop;
            {oe_d, val_d}   = apply_code(pat[0], 1'b0, val_q);
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end else if (cnt_q == '0) begin
          if (!last_slot) begin
            idx_d         = idx_inc;
            cnt_d         = per_q;
            {oe_d, val_d} = apply_code(pat[idx_inc], oe_q, val_q);
          end else if (loop_q) begin
            idx_d         = '0;
            cnt_d         = per_q;
            {oe_d, val_d} = apply_code(pat[0], oe_q, val_q);
          end else begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      per_q   <= '0;
      loop_q  <= 1'b0;
      oe_q    <= 1'b0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      per_q   <= per_d;
      loop_q  <= loop_d;
      oe_q    <= oe_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign bus.sig_oe   = oe_q;
  assign bus.sig_val  = val_q;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = done_q;
  assign bus.step_idx = idx_q;
  assign sig          = oe_q ? val_q : 1'bz;
endmodule

// File: tb/tb_sig_pattern_driver.sv
module tb_sig_pattern_driver;
  localparam int DEPTH = 8;
  localparam int DIV_W = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  sig_line;

  sig_pattern_driver_if #(.DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

  sig_pattern_driver #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .sig   (sig_line)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference state: pattern memory and line state as the spec describes them
  logic [1:0] mpat [DEPTH];
  logic       moe, mval;

  typedef struct {
    logic [7:0]  codes;   // slot i = codes[2*i +: 2], slots 0..3
    int          len;
    int          per;
    bit          lp;
    int          cycles;  // cycles observed before stop / completion
    logic [15:0] trace;   // cycle i = trace[2*i +: 2]; 0, 1, or 2 = Z
    bit          done_exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_line(input string name, input int exp);
    if (exp == 2) begin
      chk({name, "_oe"}, bus.sig_oe, 0);
    end else begin
      chk({name, "_oe"}, bus.sig_oe, 1);
      chk({name, "_val"}, bus.sig_val, exp);
      chk({name, "_sig"}, sig_line, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mpat[i] = 2'b10;
    moe  = 1'b0;
    mval = 1'b0;
  endtask

  task automatic apply_m(input logic [1:0] code);
    case (code)
      2'b00: begin moe = 1'b1; mval = 1'b0; end
      2'b01: begin moe = 1'b1; mval = 1'b1; end
      2'b10: moe = 1'b0;
      default: ;
    endcase
  endtask

  task automatic wr_slot(input int a, input logic [1:0] c);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_code = c;
    tick();
    bus.wr_en   = 1'b0;
    mpat[a]     = c;
  endtask

  task automatic start_run(input int len, input int per, input bit lp);
    bus.len    = (AW+1)'(len);
    bus.period = DIV_W'(per);
    bus.loop   = lp;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  // Timeline model: cycle k after start lies in slot (k / (per+1)) mod len; a slot's code is
  // applied on its first cycle, using memory contents from before that edge's write.
  task automatic run_model(input int len, input int per, input bit lp, input int stop_after,
                           input bit chaos);
    int len_eff, total, slot;
    bit pw;
    int pa;
    logic [1:0] pc;
    len_eff = (len > DEPTH) ? DEPTH : len;
    pw = 0; pa = 0; pc = 0;
    start_run(len, per, lp);
    if (len_eff == 0) begin
      chk("len0_busy", bus.busy, 0);
      chk("len0_done", bus.done, 1);
      chk("len0_oe", bus.sig_oe, 0);
      tick();
      chk("len0_done_clr", bus.done, 0);
      return;
    end
    total = lp ? stop_after : len_eff * (per + 1);
    for (int k = 0; k < total; k++) begin
      slot = (k / (per + 1)) % len_eff;
      if (k % (per + 1) == 0) apply_m(mpat[slot]);
      if (pw) begin mpat[pa] = pc; pw = 0; end
      chk("run_busy", bus.busy, 1);
      chk("run_done", bus.done, 0);
      chk("run_step", bus.step_idx, slot);
      chk("run_oe", bus.sig_oe, moe);
      chk("run_val", bus.sig_val, mval);
      bus.wr_en = 1'b0;
      if (chaos) begin
        if ($urandom_range(0, 3) == 0) begin
          pw = 1;
          pa = $urandom_range(0, DEPTH - 1);
          pc = 2'($urandom_range(0, 3));
          bus.wr_en   = 1'b1;
          bus.wr_addr = AW'(pa);
          bus.wr_code = pc;
        end
        bus.start  = ($urandom_range(0, 3) == 0);
        bus.len    = (AW+1)'($urandom_range(0, 15));
        bus.period = DIV_W'($urandom_range(0, 7));
        bus.loop   = 1'($urandom_range(0, 1));
      end
      if (lp && k == total - 1) bus.stop = 1'b1;
      tick();
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (pw) mpat[pa] = pc;
    moe = 1'b0;
    if (lp) begin
      chk("stop_busy", bus.busy, 0);
      chk("stop_done", bus.done, 0);
      chk("stop_oe", bus.sig_oe, 0);
      chk("stop_val", bus.sig_val, mval);
    end else begin
      chk("end_done", bus.done, 1);
      chk("end_busy", bus.busy, 0);
      chk("end_oe", bus.sig_oe, 0);
      tick();
      chk("end_done_clr", bus.done, 0);
    end
  endtask

  initial begin
    vecs[0] = '{codes: 8'hE1, len: 4, per: 0, lp: 0, cycles: 4, trace: 16'h00A1, done_exp: 1};
    vecs[1] = '{codes: 8'h9C, len: 4, per: 0, lp: 0, cycles: 4, trace: 16'h0090, done_exp: 1};
    vecs[2] = '{codes: 8'h37, len: 3, per: 1, lp: 0, cycles: 6, trace: 16'h055A, done_exp: 1};
    vecs[3] = '{codes: 8'h39, len: 2, per: 1, lp: 0, cycles: 4, trace: 16'h00A5, done_exp: 1};
    vecs[4] = '{codes: 8'hA4, len: 2, per: 2, lp: 1, cycles: 8, trace: 16'h0540, done_exp: 0};
    vecs[5] = '{codes: 8'hAB, len: 1, per: 3, lp: 0, cycles: 4, trace: 16'h00AA, done_exp: 1};
    vecs[6] = '{codes: 8'h45, len: 4, per: 0, lp: 0, cycles: 4, trace: 16'h0045, done_exp: 1};

    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_code = 0; bus.len = 0; bus.period = 0;
    bus.loop = 0; bus.start = 0; bus.stop = 0;
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_oe", bus.sig_oe, 0);
    chk("rst_val", bus.sig_val, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_step", bus.step_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // table-driven single runs and a stopped loop
    for (int v = 0; v < 7; v++) begin
      for (int s = 0; s < 4; s++) wr_slot(s, vecs[v].codes[2*s +: 2]);
      start_run(vecs[v].len, vecs[v].per, vecs[v].lp);
      for (int i = 0; i < vecs[v].cycles; i++) begin
        chk($sformatf("vec%0d_c%0d_busy", v, i), bus.busy, 1);
        chk_line($sformatf("vec%0d_c%0d", v, i), int'(vecs[v].trace[2*i +: 2]));
        if (vecs[v].lp && i == vecs[v].cycles - 1) bus.stop = 1'b1;
        tick();
      end
      bus.stop = 1'b0;
      chk($sformatf("vec%0d_done", v), bus.done, vecs[v].done_exp);
      chk($sformatf("vec%0d_busy_end", v), bus.busy, 0);
      chk($sformatf("vec%0d_oe_end", v), bus.sig_oe, 0);
      tick();
      chk($sformatf("vec%0d_done_clr", v), bus.done, 0);
    end

    // start with len=0: done pulse only; start+stop together in IDLE: nothing
    start_run(0, 0, 0);
    chk("len0_busy", bus.busy, 0);
    chk("len0_done", bus.done, 1);
    chk("len0_oe", bus.sig_oe, 0);
    tick();
    chk("len0_done_once", bus.done, 0);
    bus.stop = 1'b1;
    start_run(2, 0, 0);
    bus.stop = 1'b0;
    chk("startstop_busy", bus.busy, 0);
    chk("startstop_done", bus.done, 0);

    // start pulse mid-run ignored; write to the playing slot shows up on its next visit
    wr_slot(0, 2'b00);
    wr_slot(1, 2'b01);
    start_run(2, 1, 1);
    chk_line("w_c0", 0);
    bus.start = 1'b1; bus.len = '0;
    tick();
    bus.start = 1'b0;
    chk("w_c1_busy", bus.busy, 1);
    chk("w_c1_step", bus.step_idx, 0);
    chk_line("w_c1", 0);
    tick();
    chk("w_c2_step", bus.step_idx, 1);
    chk_line("w_c2", 1);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_code = 2'b10;
    tick();
    bus.wr_en = 1'b0;
    chk_line("w_c3_cur", 1);
    tick();
    chk("w_c4_step", bus.step_idx, 0);
    chk_line("w_c4", 0);
    tick();
    tick();
    chk("w_c6_step", bus.step_idx, 1);
    chk_line("w_c6_next", 2);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("w_stop_busy", bus.busy, 0);

    // async reset mid-run while driving 1
    wr_slot(0, 2'b01);
    start_run(1, 10, 1);
    tick();
    chk_line("r_pre", 1);
    chk("r_pre_busy", bus.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("r_oe", bus.sig_oe, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick();
    run_model(8, 0, 0, 0, 0);

    // randomized runs with writes, start noise and config changes during RUN
    for (int r = 0; r < 40; r++) begin
      for (int w = 0; w < 3; w++)
        wr_slot($urandom_range(0, DEPTH - 1), 2'($urandom_range(0, 3)));
      run_model($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(1, 30), 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
